cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Collects completed results from up to N_SRC functional-unit reservation stations and serialises them onto the single common data bus (CDB), one broadcast per clock. It is the receiving end of every unit's result-broadcast interface and the driver of the CDB that all reservation stations and the register-status logic snoop. Each source gets a one-entry holding slot, and a round-robin arbiter drains the slots.

## Interface
- N_SRC, 4, number of result sources (2..8)
- TAG_W, 5, reservation-station tag width
- VAL_W, 32, result value width
- INVALID_TAG, 5'b11111, tag driven when no broadcast is active
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  N_SRC  per-source result valid
- in_tag  in  N_SRC*TAG_W  per-source tag; source i occupies bits [i*TAG_W +: TAG_W]
- in_val  in  N_SRC*VAL_W  per-source result value, packed the same way
- in_setcc  in  N_SRC  per-source: result updates ICC
- in_icc  in  N_SRC*4  per-source ICC flags {c,v,z,n}
- out_ready  out  N_SRC  per-source: slot can accept this cycle
- out_CDB_broadcast  out  1  CDB valid, one-cycle pulse per result
- out_CDB_tag  out  TAG_W  broadcast tag
- out_CDB_val  out  VAL_W  broadcast value
- out_CDB_src  out  $clog2(N_SRC)  index of the winning source
- out_ICC_valid  out  1  broadcast carries ICC update
- out_ICC_flags  out  4  {c,v,z,n}

## Operation
- Per source i, there is a slot {occ, tag, val, setcc, icc}.
- Handshake: a transfer happens when in_valid[i] & out_ready[i] are both high at a rising edge. The slot captures the source's fields and occ is set. in_valid with out_ready low is held by the source; the block does not drop it.
- out_ready[i] = !occ[i] | grant[i]. This is combinational and allows a same-edge drain and refill.
- Arbiter (combinational): scan the sources starting at ptr, wrapping modulo N_SRC. grant goes to the first occupied slot. At most one grant is issued per cycle.
- On an edge with a grant w:
  - Register the outputs from slot w and set out_CDB_broadcast=1.
  - out_CDB_src=w.
  - out_ICC_valid=setcc[w].
  - Clear occ[w] unless it is refilled on the same edge.
  - ptr <= (w+1) mod N_SRC.
- On an edge with no grant:
  - out_CDB_broadcast=0, out_ICC_valid=0, out_CDB_tag=INVALID_TAG.
  - out_CDB_val and out_ICC_flags hold their last values.
  - ptr is unchanged.
- out_ICC_flags updates only when setcc[w]=1.
- No value arithmetic is performed. Fields pass through bit-exact, and value width is VAL_W with no truncation.

## Timing
- Reset values:
  - occ all 0, ptr 0.
  - out_CDB_broadcast 0, out_ICC_valid 0, out_CDB_tag INVALID_TAG.
  - out_CDB_val 0, out_CDB_src 0, out_ICC_flags 0.
  - out_ready all 1, since it is combinational from occ.
- Reset mid-operation discards all held results immediately, with no broadcast.
- Latency: accept at edge k means the earliest broadcast is visible in the cycle following edge k+1 (a 1-cycle slot plus 1 registered output stage).
- Throughput:
  - One broadcast per cycle total.
  - A single source may stream one result every cycle when it is uncontended.
  - With all N_SRC sources continuously valid, each source is granted exactly once every N_SRC cycles.
- Starvation bound: an occupied slot is broadcast within N_SRC cycles.
- All slots full and no new valids: drains in N_SRC consecutive cycles, then the CDB goes idle.

## Structure
- Shared tomasulo package:
  - TAG_W, VAL_W, INVALID_TAG
  - ICC flag bit ordering {c,v,z,n}
  - a cdb_msg_t typedef {tag, val, setcc, icc}
- Sub-module rr_arbiter (N parameter): inputs req[N] and ptr; outputs a one-hot grant and its index. It is reused by future issue-queue selection logic.
- The top level holds the slots, the pointer update and the output registers.

## Test plan
- Reset state: assert rst mid-stream with 2 slots occupied -> outputs go to reset values immediately; no broadcast after deassert; out_ready=4'b1111.
- Single source: source 2 sends tag 5'd6, val 32'h0000_0015, setcc=1, icc 4'b0000 -> exactly one cycle with broadcast=1, tag 6, val 0x15, src 2, ICC_valid=1, flags 0000.
- Contention: all 4 sources are valid on the same edge with tags 0..3 and ptr=0 -> broadcasts of tags 0,1,2,3 in consecutive cycles, then idle with tag 5'b11111.
- Round-robin fairness: sources 0 and 3 are held continuously valid for 8 cycles -> grants alternate 0,3,0,3…; neither source waits more than 1 cycle between grants.
- Backpressure and refill: source 1 sends 2 back-to-back results while source 0 holds the CDB -> out_ready[1]=0 until slot 1 is granted, then refills on the grant edge; both values are broadcast in order with no loss or duplication.
- ICC hold: a setcc=1 result with flags 4'b0010 is followed by a setcc=0 result -> the second broadcast has ICC_valid=0 and flags still 4'b0010.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared Tomasulo CDB types and constants.
// Tag/value widths, idle tag and ICC flag layout.
package cdb_arbiter_pkg;

  localparam int TAG_W = 5;
  localparam int VAL_W = 32;
  localparam logic [TAG_W-1:0] INVALID_TAG = 5'b11111;

  localparam int ICC_N = 0;
  localparam int ICC_Z = 1;
  localparam int ICC_V = 2;
  localparam int ICC_C = 3;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [VAL_W-1:0] val;
    logic             setcc;
    logic [3:0]       icc;
  } cdb_msg_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-broadcast bundle between functional units and the CDB.
// master = result sources side, slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int N_SRC = 4
);
  import cdb_arbiter_pkg::*;

  localparam int SW = $clog2(N_SRC);

  logic [N_SRC-1:0]       in_valid;
  logic [N_SRC*TAG_W-1:0] in_tag;
  logic [N_SRC*VAL_W-1:0] in_val;
  logic [N_SRC-1:0]       in_setcc;
  logic [N_SRC*4-1:0]     in_icc;
  logic [N_SRC-1:0]       out_ready;
  logic                   out_CDB_broadcast;
  logic [TAG_W-1:0]       out_CDB_tag;
  logic [VAL_W-1:0]       out_CDB_val;
  logic [SW-1:0]          out_CDB_src;
  logic                   out_ICC_valid;
  logic [3:0]             out_ICC_flags;

  modport master (
    output in_valid, in_tag, in_val,
    output in_setcc, in_icc,
    input  out_ready,
    input  out_CDB_broadcast, out_CDB_tag,
    input  out_CDB_val, out_CDB_src,
    input  out_ICC_valid, out_ICC_flags
  );

  modport slave (
    input  in_valid, in_tag, in_val,
    input  in_setcc, in_icc,
    output out_ready,
    output out_CDB_broadcast, out_CDB_tag,
    output out_CDB_val, out_CDB_src,
    output out_ICC_valid, out_ICC_flags
  );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin picker: first request at or after ptr, wrapping.
// Shared with issue-queue select logic.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Per-source one-entry result slots drained round-robin
// onto the common data bus, one broadcast per clock.
module cdb_arbiter #(
  parameter int N_SRC = 4
) (
  input logic         clk,
  input logic         rst,
  cdb_arbiter_if.slave bus
);
  import cdb_arbiter_pkg::*;

  localparam int SW = $clog2(N_SRC);

  logic [N_SRC-1:0] occ;
  logic [N_SRC-1:0] gnt;
  logic [N_SRC-1:0] acc;
  logic [SW-1:0]    ptr;
  logic [SW-1:0]    g_idx;
  logic             any;
  cdb_msg_t         slot [N_SRC];

  logic             bc_q;
  logic [TAG_W-1:0] tag_q;
  logic [VAL_W-1:0] val_q;
  logic [SW-1:0]    src_q;
  logic             iccv_q;
  logic [3:0]       icc_q;

  rr_arbiter #(.N(N_SRC), .PW(SW)) u_rr (
    .req (occ),
    .ptr (ptr),
    .gnt (gnt),
    .idx (g_idx)
  );

  assign any = |gnt;
  // a granted slot may be refilled on the edge it drains
  assign acc = bus.in_valid & (~occ | gnt);

  assign bus.out_ready         = ~occ | gnt;
  assign bus.out_CDB_broadcast = bc_q;
  assign bus.out_CDB_tag       = tag_q;
  assign bus.out_CDB_val       = val_q;
  assign bus.out_CDB_src       = src_q;
  assign bus.out_ICC_valid     = iccv_q;
  assign bus.out_ICC_flags     = icc_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (acc[i]) begin
        slot[i].tag   <= bus.in_tag[i*TAG_W +: TAG_W];
        slot[i].val   <= bus.in_val[i*VAL_W +: VAL_W];
        slot[i].setcc <= bus.in_setcc[i];
        slot[i].icc   <= bus.in_icc[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= '0;
      ptr    <= '0;
      bc_q   <= 1'b0;
      tag_q  <= INVALID_TAG;
      val_q  <= '0;
      src_q  <= '0;
      iccv_q <= 1'b0;
      icc_q  <= '0;
    end else begin
      occ <= acc | (occ & ~gnt);
      if (any) begin
        bc_q   <= 1'b1;
        tag_q  <= slot[g_idx].tag;
        val_q  <= slot[g_idx].val;
        src_q  <= g_idx;
        iccv_q <= slot[g_idx].setcc;
        if (slot[g_idx].setcc)
          icc_q <= slot[g_idx].icc;
        ptr <= (g_idx == SW'(N_SRC-1)) ? '0 : g_idx + 1'b1;
      end else begin
        bc_q   <= 1'b0;
        iccv_q <= 1'b0;
        tag_q  <= INVALID_TAG;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter.
// Inputs driven and outputs sampled on the falling edge.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_asrt = 0;
  int   n_fail = 0;

  cdb_arbiter_if #(.N_SRC(4)) bus ();

  cdb_arbiter #(.N_SRC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(string t, logic [63:0] o, logic [63:0] e);
    n_asrt++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic put(int i, logic [4:0] tg, logic [31:0] v,
                     logic sc, logic [3:0] f);
    bus.in_valid[i]              = 1'b1;
    bus.in_tag[i*TAG_W +: TAG_W] = tg;
    bus.in_val[i*VAL_W +: VAL_W] = v;
    bus.in_setcc[i]              = sc;
    bus.in_icc[i*4 +: 4]         = f;
  endtask

  task automatic bc(string t, logic [4:0] tg,
                    logic [31:0] v, logic [1:0] s);
    chk({t, "_bc"},  bus.out_CDB_broadcast, 1'b1);
    chk({t, "_tag"}, bus.out_CDB_tag, tg);
    chk({t, "_val"}, bus.out_CDB_val, v);
    chk({t, "_src"}, bus.out_CDB_src, s);
  endtask

  task automatic idle(string t);
    chk({t, "_bc"},  bus.out_CDB_broadcast, 1'b0);
    chk({t, "_tag"}, bus.out_CDB_tag, 5'b11111);
    chk({t, "_iccv"}, bus.out_ICC_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = '0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = '0;
    bus.in_tag   = '0;
    bus.in_val   = '0;
    bus.in_setcc = '0;
    bus.in_icc   = '0;
    cyc();

    // reset values
    idle("rst");
    chk("rst_val", bus.out_CDB_val, 32'h0);
    chk("rst_src", bus.out_CDB_src, 2'd0);
    chk("rst_flags", bus.out_ICC_flags, 4'h0);
    chk("rst_rdy", bus.out_ready, 4'b1111);
    rst = 1'b0;

    // single source
    put(2, 5'd6, 32'h0000_0015, 1'b1, 4'b0000);
    chk("s1_rdy", bus.out_ready[2], 1'b1);
    cyc();
    bus.in_valid = '0;
    chk("s1_lat", bus.out_CDB_broadcast, 1'b0);
    cyc();
    bc("s1", 5'd6, 32'h0000_0015, 2'd2);
    chk("s1_iccv", bus.out_ICC_valid, 1'b1);
    chk("s1_flags", bus.out_ICC_flags, 4'b0000);
    cyc();
    idle("s1_idle");
    chk("s1_hold", bus.out_CDB_val, 32'h0000_0015);

    // contention, ptr back at 0
    do_reset();
    for (int i = 0; i < 4; i++)
      put(i, 5'(i), 32'hA000_0100 + 32'(i), 1'b0, 4'hF);
    cyc();
    bus.in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      bc("ct", 5'(i), 32'hA000_0100 + 32'(i), 2'(i));
      chk("ct_iccv", bus.out_ICC_valid, 1'b0);
    end
    cyc();
    idle("ct_idle");
    chk("ct_flags", bus.out_ICC_flags, 4'h0);

    // fairness between sources 0 and 3
    put(0, 5'd10, 32'hB000_000A, 1'b0, 4'h0);
    put(3, 5'd13, 32'hB000_000D, 1'b0, 4'h0);
    for (int n = 1; n <= 10; n++) begin
      cyc();
      if (n == 8) bus.in_valid = '0;
      if (n >= 2) begin
        if (n % 2 == 0)
          bc("rr", 5'd10, 32'hB000_000A, 2'd0);
        else
          bc("rr", 5'd13, 32'hB000_000D, 2'd3);
      end
    end
    cyc();
    idle("rr_idle");

    // backpressure and same-edge refill
    do_reset();
    put(0, 5'd20, 32'hC000_0014, 1'b0, 4'h0);
    put(1, 5'd21, 32'hC000_0015, 1'b0, 4'h0);
    cyc();
    bus.in_valid[0] = 1'b0;
    put(1, 5'd22, 32'hC000_0016, 1'b0, 4'h0);
    chk("bp_rdy1", bus.out_ready, 4'b1101);
    chk("bp_lat", bus.out_CDB_broadcast, 1'b0);
    cyc();
    bc("bp0", 5'd20, 32'hC000_0014, 2'd0);
    chk("bp_rdy2", bus.out_ready, 4'b1111);
    cyc();
    bus.in_valid = '0;
    bc("bp1", 5'd21, 32'hC000_0015, 2'd1);
    cyc();
    bc("bp2", 5'd22, 32'hC000_0016, 2'd1);
    cyc();
    idle("bp_idle");

    // ICC hold across setcc=0
    put(2, 5'd7, 32'hD000_0007, 1'b1, 4'b0010);
    cyc();
    put(2, 5'd8, 32'hD000_0008, 1'b0, 4'b1111);
    cyc();
    bus.in_valid = '0;
    bc("ic1", 5'd7, 32'hD000_0007, 2'd2);
    chk("ic1_iccv", bus.out_ICC_valid, 1'b1);
    chk("ic1_flags", bus.out_ICC_flags, 4'b0010);
    cyc();
    bc("ic2", 5'd8, 32'hD000_0008, 2'd2);
    chk("ic2_iccv", bus.out_ICC_valid, 1'b0);
    chk("ic2_flags", bus.out_ICC_flags, 4'b0010);
    cyc();
    idle("ic_idle");
    chk("ic_hold", bus.out_ICC_flags, 4'b0010);

    // reset mid-stream with slots 0 and 1 still held
    put(0, 5'd24, 32'hE000_0018, 1'b0, 4'h0);
    put(1, 5'd25, 32'hE000_0019, 1'b0, 4'h0);
    put(3, 5'd27, 32'hE000_001B, 1'b0, 4'h0);
    cyc();
    bus.in_valid = '0;
    chk("mr_rdy", bus.out_ready, 4'b1100);
    cyc();
    bc("mr", 5'd27, 32'hE000_001B, 2'd3);
    rst = 1'b1;
    #1;
    idle("mr_rst");
    chk("mr_val", bus.out_CDB_val, 32'h0);
    chk("mr_src", bus.out_CDB_src, 2'd0);
    chk("mr_flags", bus.out_ICC_flags, 4'h0);
    chk("mr_rdy0", bus.out_ready, 4'b1111);
    cyc();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cyc();
      idle("mr_post");
      chk("mr_rdy1", bus.out_ready, 4'b1111);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
